// File: rtl/drom_streamer.sv
// drom_streamer: arbitrates string-fetch requests from two requesters onto the
// single data ROM port and streams each 16-bit word over valid/ready until a
// 0x0000 terminator is read or the requester's length limit is reached.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   req0/req1           level requests, sampled only while idle
//   start0/start1       first ROM address of each requester's string
//   maxlen0/maxlen1     maximum words to emit for each requester
//   grant               one-hot owner of the current transaction (0 when idle)
//   busy                high whenever a transaction is in progress
//   rom_address         registered ROM address
//   rom_data            ROM word at rom_address
//   char_data/valid     streamed word and its valid flag
//   char_ready          sink accepts char_data
//   done                one-cycle pulse on the owner's bit at end of transaction
//
// Build option: DROM_STREAMER_FIXED_PRIO_EN selects fixed priority (requester 0
// wins every tie); without it ties are resolved round-robin.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request; arbitration happens here
// FETCH  | rom_address stable, decide terminator / limit / emit
// SEND   | char_valid held until the sink takes the word
// DONE   | done pulse for the owner, grant released on exit

module drom_streamer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] start0,
  input  logic [ADDR_W-1:0] start1,
  input  logic [LEN_W-1:0]  maxlen0,
  input  logic [LEN_W-1:0]  maxlen1,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] char_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [1:0]        done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

  state_t              state, state_d;
  logic [1:0]          grant_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   char_data_d;
  logic                char_valid_d;
  logic [LEN_W-1:0]    count, count_d;
  logic [LEN_W-1:0]    limit, limit_d;
  logic                pick1;

`ifdef DROM_STREAMER_FIXED_PRIO_EN
  assign pick1 = !req0;
`else
  // last_owner: 1 means requester 1 owned the previous transaction.
  logic last_owner, last_owner_d;
  assign pick1 = req1 && (!req0 || !last_owner);
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE) ? grant : 2'b00;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      grant       <= 2'b00;
      rom_address <= '0;
      char_data   <= '0;
      char_valid  <= 1'b0;
      count       <= '0;
      limit       <= '0;
`ifdef DROM_STREAMER_FIXED_PRIO_EN
`else
      last_owner  <= 1'b1;
`endif
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      rom_address <= addr_d;
      char_data   <= char_data_d;
      char_valid  <= char_valid_d;
      count       <= count_d;
      limit       <= limit_d;
`ifdef DROM_STREAMER_FIXED_PRIO_EN
`else
      last_owner  <= last_owner_d;
`endif
    end
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    addr_d       = rom_address;
    char_data_d  = char_data;
    char_valid_d = char_valid;
    count_d      = count;
    limit_d      = limit;
`ifdef DROM_STREAMER_FIXED_PRIO_EN
`else
    last_owner_d = last_owner;
`endif
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          if (pick1) begin
            grant_d = 2'b10;
            addr_d  = start1;
            limit_d = maxlen1;
          end else begin
            grant_d = 2'b01;
            addr_d  = start0;
            limit_d = maxlen0;
          end
          count_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // The terminator itself is never emitted; a zero limit ends at once.
        if (rom_data == '0 || count == limit) begin
          state_d = S_DONE;
        end else begin
          char_data_d  = rom_data;
          char_valid_d = 1'b1;
          state_d      = S_SEND;
        end
      end
      S_SEND: begin
        if (char_ready) begin
          char_valid_d = 1'b0;
          count_d      = count + LEN_W'(1);
          addr_d       = rom_address + ADDR_W'(1);  // wraps silently
          state_d      = S_FETCH;
        end
      end
      S_DONE: begin
        grant_d = 2'b00;
`ifdef DROM_STREAMER_FIXED_PRIO_EN
`else
        last_owner_d = grant[1];
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
